// File: rtl/alu_modexp_ctrl.sv
// Modular exponentiation sequencer: computes base^exp mod p by issuing
// LOADMOD/MODMUL commands to the ECC ALU using left-to-right square-and-multiply.
module alu_modexp_ctrl #(
    parameter int WIDTH = 129,
    parameter int EXP_W = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mod_p_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             alu_en_o,
    output logic [1:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_P_o,
    output logic [WIDTH-1:0] alu_Q_o,
    input  logic [WIDTH-1:0] alu_R_i,
    input  logic             alu_done_i
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [1:0] OP_MODMUL  = 2'd0;
    localparam logic [1:0] OP_LOADMOD = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_LOADMOD, S_WAIT_LD, S_SCAN, S_SQR,
        S_WAIT_SQR, S_MUL, S_WAIT_MUL, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   base_q, base_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               first_q, first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               alu_en_q, alu_en_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_p_q, alu_p_d;
    logic [WIDTH-1:0]   alu_q_q, alu_q_d;
    logic               alu_done_prev_q;
    logic               alu_complete;

    // Only a rising edge counts, so a level left high by the previous op is never mistaken for completion.
    assign alu_complete = alu_done_i && !alu_done_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            exp_q           <= '0;
            acc_q           <= '0;
            idx_q           <= '0;
            first_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            result_q        <= '0;
            alu_en_q        <= 1'b0;
            alu_op_q        <= 2'd0;
            alu_p_q         <= '0;
            alu_q_q         <= '0;
            alu_done_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            exp_q           <= exp_d;
            acc_q           <= acc_d;
            idx_q           <= idx_d;
            first_q         <= first_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            result_q        <= result_d;
            alu_en_q        <= alu_en_d;
            alu_op_q        <= alu_op_d;
            alu_p_q         <= alu_p_d;
            alu_q_q         <= alu_q_d;
            alu_done_prev_q <= alu_done_i;
        end
    end

    // Command registers are loaded on the transition into an issue state so
    // alu_en and operands appear together and stay stable through the wait.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        first_d  = first_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        alu_en_d = 1'b0;
        alu_op_d = alu_op_q;
        alu_p_d  = alu_p_q;
        alu_q_d  = alu_q_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d  = base_i;
                    exp_d   = exp_i;
                    acc_d   = WIDTH'(1);
                    idx_d   = IDX_W'(EXP_W - 1);
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                    if (exp_i == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_LOADMOD;
                        alu_en_d = 1'b1;
                        alu_op_d = OP_LOADMOD;
                        alu_p_d  = mod_p_i;
                        alu_q_d  = mod_p_i;
                    end
                end
            end
            S_LOADMOD: state_d = S_WAIT_LD;
            S_WAIT_LD: begin
                if (alu_complete) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (first_q) begin
                    if (exp_q[idx_q]) begin
                        first_d  = 1'b0;
                        state_d  = S_MUL;
                        alu_en_d = 1'b1;
                        alu_op_d = OP_MODMUL;
                        alu_p_d  = acc_q;
                        alu_q_d  = base_q;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    state_d  = S_SQR;
                    alu_en_d = 1'b1;
                    alu_op_d = OP_MODMUL;
                    alu_p_d  = acc_q;
                    alu_q_d  = acc_q;
                end
            end
            S_SQR: state_d = S_WAIT_SQR;
            S_MUL: state_d = S_WAIT_MUL;
            S_WAIT_SQR: begin
                if (alu_complete) begin
                    acc_d = alu_R_i;
                    if (exp_q[idx_q]) begin
                        state_d  = S_MUL;
                        alu_en_d = 1'b1;
                        alu_op_d = OP_MODMUL;
                        alu_p_d  = alu_R_i;
                        alu_q_d  = base_q;
                    end else if (idx_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            S_WAIT_MUL: begin
                if (alu_complete) begin
                    acc_d = alu_R_i;
                    if (idx_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            S_FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign alu_en_o = alu_en_q;
    assign alu_op_o = alu_op_q;
    assign alu_P_o  = alu_p_q;
    assign alu_Q_o  = alu_q_q;

endmodule

// File: tb/tb_alu_modexp_ctrl.sv
// Self-checking bench for alu_modexp_ctrl with a behavioural 5-cycle ALU
// (pulse or held alu_done) and scoreboard queues for opcodes and results.
module tb_alu_modexp_ctrl;

    localparam int WIDTH = 129;
    localparam int EXP_W = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] modP, base;
    logic [EXP_W-1:0] expn;
    logic             busy, done, aluEn, aluDone;
    logic [WIDTH-1:0] result, aluP, aluQ, aluR;
    logic [1:0]       aluOp;

    int testsRun = 0;
    int testsFailed = 0;
    int aluEnSeen = 0;
    logic holdMode = 1'b0;
    logic prevEn = 1'b0;
    logic [WIDTH-1:0] curMod = '0;

    logic [1:0]       expOp[$];
    logic [WIDTH-1:0] expRes[$];

    always #5 clk = ~clk;

    alu_modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .mod_p_i(modP), .base_i(base), .exp_i(expn),
        .busy_o(busy), .done_o(done), .result_o(result),
        .alu_en_o(aluEn), .alu_op_o(aluOp), .alu_P_o(aluP), .alu_Q_o(aluQ),
        .alu_R_i(aluR), .alu_done_i(aluDone)
    );

    function automatic logic [127:0] modMul(input logic [127:0] a, input logic [127:0] b,
                                            input logic [127:0] m);
        logic [255:0] prod;
        prod = {128'd0, a} * {128'd0, b};
        return 128'(prod % {128'd0, m});
    endfunction

    // Behavioural ALU: result 5 cycles after the command; done pulses or holds until the next command.
    logic [127:0]     modReg;
    logic [1:0]       opReg;
    logic [WIDTH-1:0] pReg, qReg;
    int               latCnt;
    always @(posedge clk) begin
        if (rst) begin
            aluDone <= 1'b0;
            aluR    <= '0;
            latCnt  <= 0;
            modReg  <= '0;
        end else if (aluEn) begin
            opReg   <= aluOp;
            pReg    <= aluP;
            qReg    <= aluQ;
            latCnt  <= 5;
            aluDone <= 1'b0;
        end else if (latCnt > 0) begin
            latCnt <= latCnt - 1;
            if (latCnt == 1) begin
                aluDone <= 1'b1;
                if (opReg == 2'd2) modReg <= pReg[127:0];
                else aluR <= {1'b0, modMul(pReg[127:0], qReg[127:0], modReg)};
            end
        end else if (!holdMode) begin
            aluDone <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every command strobe and every done pulse.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prevEn = 1'b0;
        end else begin
            if (aluEn) begin
                aluEnSeen++;
                checkOutput("aluEnWidth", prevEn, 0);
                checkOutput("opQueueNonEmpty", expOp.size() > 0, 1);
                if (expOp.size() > 0) checkOutput("aluOp", aluOp, expOp.pop_front());
                if (aluOp == 2'd2) begin
                    checkOutput("loadModP", aluP, curMod);
                    checkOutput("loadModQ", aluQ, curMod);
                end
            end
            if (done) begin
                checkOutput("resQueueNonEmpty", expRes.size() > 0, 1);
                if (expRes.size() > 0) checkOutput("result", result, expRes.pop_front());
            end
            prevEn = aluEn;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] b,
                                 input logic [EXP_W-1:0] e, input logic [WIDTH-1:0] want,
                                 input int nModMul);
        @(negedge clk);
        curMod = p;
        modP   = p;
        base   = b;
        expn   = e;
        if (e != '0) begin
            expOp.push_back(2'd2);
            for (int k = 0; k < nModMul; k++) expOp.push_back(2'd0);
        end
        expRes.push_back(want);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyRise", busy, 1);
    endtask

    task automatic waitDone(input string tag, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, done, 1);
        checkOutput("busyFall", busy, 0);
    endtask

    task automatic finishRun();
        int n;
        waitDone("doneSeen", n);
        repeat (3) @(negedge clk);
        checkOutput("opsRemaining", expOp.size(), 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        modP  = '0;
        base  = '0;
        expn  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstAluEn", aluEn, 0);
        checkOutput("rstAluOp", aluOp, 0);
        checkOutput("rstAluP", aluP, 0);
        checkOutput("rstAluQ", aluQ, 0);
        checkOutput("rstResult", result, 0);
        rst = 1'b0;

        // exp = 3 and exp = 15 (inverse of 5 mod 17) with the pulse model
        applyStimulus(17, 5, 3, 6, 3);
        finishRun();
        applyStimulus(17, 5, 15, 7, 7);
        finishRun();

        // exp = 16 under both ALU models
        applyStimulus(17, 3, 16, 1, 5);
        finishRun();
        holdMode = 1'b1;
        applyStimulus(17, 3, 16, 1, 5);
        finishRun();
        applyStimulus(17, 5, 15, 7, 7);
        finishRun();
        holdMode = 1'b0;
        repeat (2) @(negedge clk);

        // exp = 0: done exactly 2 cycles after start, no ALU traffic
        aluEnSeen = 0;
        applyStimulus(17, 9, 0, 1, 0);
        checkOutput("zeroExpDoneEarly", done, 0);
        waitDone("zeroExpDone", n);
        checkOutput("zeroExpLatency", n, 1);
        repeat (3) @(negedge clk);
        checkOutput("zeroExpAluEn", aluEnSeen, 0);

        // Reset in WAIT_SQR of the exp = 15 run
        aluEnSeen = 0;
        applyStimulus(17, 5, 15, 7, 7);
        n = 0;
        while (aluEnSeen < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachSqr", aluEnSeen, 3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expOp.delete();
        expRes.delete();
        @(negedge clk);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstAluEn", aluEn, 0);
        checkOutput("midRstAluOp", aluOp, 0);
        checkOutput("midRstAluP", aluP, 0);
        checkOutput("midRstAluQ", aluQ, 0);
        checkOutput("midRstResult", result, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midRstIdle", busy, 0);
        applyStimulus(17, 5, 3, 6, 3);
        finishRun();

        // start while busy is ignored
        applyStimulus(17, 5, 3, 6, 3);
        repeat (4) @(negedge clk);
        modP  = 23;
        base  = 3;
        expn  = 16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finishRun();
        repeat (20) @(negedge clk);
        checkOutput("noRestart", busy, 0);

        // Large modulus 2^127-1, base 2, exp 127: 6 squarings + 7 multiplies
        applyStimulus({2'b00, {127{1'b1}}}, 2, 127, 1, 13);
        finishRun();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_modexp_ctrl.md
# alu_modexp_ctrl

Sequencer that computes `base^exp mod p` by driving the 129-bit ECC ALU as its command initiator. It issues `alu_en` / `alu_op` / `alu_P` / `alu_Q` commands and consumes `alu_R` / `alu_done`. It sits between the point-arithmetic layer and the ALU. Its main use is field inversion via `exp = p-2`, so the upper layer never sequences individual modular multiplies itself.

## Interface
Parameters:
- `WIDTH`, 129: operand width, `{1-bit sign, 128-bit magnitude}`, same format as the ALU.
- `EXP_W`, 128: exponent width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `mod_p`  in  WIDTH  modulus; latched on accepted `start`.
- `base`  in  WIDTH  base operand; latched on accepted `start`.
- `exp`  in  EXP_W  exponent; latched on accepted `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  WIDTH  final value; held until the next accepted `start`.
- `alu_en`  out  1  one-cycle command strobe to the ALU.
- `alu_op`  out  2  ALU opcode: `2'd2` LOADMOD (P=Q=modulus), `2'd0` MODMUL (R = P·Q mod p).
- `alu_P`, `alu_Q`  out  WIDTH  ALU operands.
- `alu_R`  in  WIDTH  ALU result.
- `alu_done`  in  1  ALU completion (pulse or level).

## Operation
- States: IDLE, LOADMOD, WAIT_LD, SCAN, SQR, WAIT_SQR, MUL, WAIT_MUL, FIN.
- **IDLE**
  - On `start`: latch inputs, set `acc` = 1, set bit index `i` = EXP_W-1, set `first` = 1.
  - If `exp == 0`: go to FIN with `acc` = 1. No ALU command is issued.
  - Otherwise go to LOADMOD.
- **LOADMOD**: issue `alu_op` = 2, `alu_P` = `alu_Q` = `mod_p`, then go to WAIT_LD.
- **SCAN** (one exponent bit per cycle, MSB first)
  - While `first` and `exp[i] == 0`: decrement `i` (leading-zero skip, no ALU op).
  - If `first` and `exp[i] == 1`: clear `first` and go to MUL. The squaring of 1 is skipped.
  - If not `first`: go to SQR.
- **SQR**: issue MODMUL with P = Q = `acc`, then go to WAIT_SQR. On completion `acc` ← `alu_R`; if `exp[i]` go to MUL, else go to the bit-advance step.
- **MUL**: issue MODMUL with P = `acc`, Q = `base`, then go to WAIT_MUL. On completion `acc` ← `alu_R`, then bit-advance.
- **Bit-advance**: if `i == 0` go to FIN; else `i` ← `i-1` and go to SCAN.
- **FIN**: `result` ← `acc`, pulse `done`, return to IDLE.
- ALU op count for an exponent with k significant bits and popcount w: 1 LOADMOD + (k-1) SQR + w MUL.
- The sign bit is carried as-is from `alu_R`; no sign handling here.
- `start` while `busy` is ignored.
- WAIT_LD completion goes to SCAN.

## Timing
- Reset values: `busy`=0, `done`=0, `alu_en`=0, `alu_op`=0, `alu_P`=0, `alu_Q`=0, `result`=0, state IDLE.
- Latency from `start` to `busy`: `busy` rises in the cycle after `start` and falls in the cycle `done` pulses.
- Command issue:
  - `alu_en` is high for exactly one cycle, in the LOADMOD, SQR or MUL state.
  - `alu_P`, `alu_Q` and `alu_op` are valid in that cycle and held stable until completion is accepted.
- Completion rule (WAIT_* states only):
  - Completion = `alu_done` high while the registered `alu_done` from the previous cycle was low (rising edge).
  - A level held high from the previous operation is never taken as completion.
  - `alu_done` outside WAIT_* states is ignored.
- Next command issues 1 cycle (SQR→MUL) or 2 cycles (through SCAN) after completion is accepted.
- Leading-zero skipping costs 1 cycle per zero bit.
- `exp == 0`: `done` pulses 2 cycles after `start` with `result` = 1, and `alu_en` never rises.
- `rst` mid-operation:
  - Return to IDLE at the next edge with all outputs at reset values; no `done` is produced.
  - The ALU shares `rst` and is reset in the same cycle.

## Test plan
Use a behavioural ALU model with 5-cycle latency and a one-cycle `alu_done` pulse, and a second model that holds `alu_done` high until the next `alu_en`.
- `p`=17, `base`=5, `exp`=3 → `result`=6; exactly 4 `alu_en` pulses with ops 2, 0, 0, 0 (LOADMOD, MUL, SQR, MUL).
- `p`=17, `base`=5, `exp`=15 → `result`=7 (the inverse of 5); 1 LOADMOD + 3 SQR + 4 MUL = 8 commands.
- `p`=17, `base`=3, `exp`=16 → `result`=1; command sequence LOADMOD, MUL, SQR×4; both ALU models give the same result.
- `exp`=0, `base`=9 → `done` 2 cycles after `start`, `result`=1, zero `alu_en` pulses.
- Assert `rst` during WAIT_SQR of the `exp`=15 run → outputs at reset values next cycle, no `done`. A fresh `start` with `base`=5, `exp`=3 then gives `result`=6.
- `start` pulsed again while `busy` with different operands → ignored; the first result is unchanged. Large case: `p` = 2^127−1, `base`=2, `exp`=127 → `result`=1.
